// File: rtl/uart_cmd_rx_pkg.sv
// Shared UART constants and receiver state encoding; BAUD/HALF defaults match UART_tx (50 MHz, 19200 baud).
package uart_pkg;

    localparam int BAUD_CYCLES_DFLT = 2604;
    localparam int HALF_CYCLES_DFLT = BAUD_CYCLES_DFLT / 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_cmd_rx_sync.sv
// Two-flop RX synchronizer plus falling-edge detect; rx_s lags the pin by 2 clk, fall is combinational off rx_s.
// No backpressure: free-running, every flop presets to idle-high so reset never looks like a start edge.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= rx;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rx_s = r_sync;
    assign fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_cmd_rx.sv
// 8N1 command-byte receiver; rdy rises ~3+HALF+9*BAUD clk after the RX pin falls, sticky until clr_rdy or next start edge.
// No backpressure: an uncleared byte is overwritten by the next good frame; UART_RX_FRAME_CHK_EN enables stop-bit checking.
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int BAUD_CYCLES = BAUD_CYCLES_DFLT,
    parameter int HALF_CYCLES = BAUD_CYCLES / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD_CYCLES);
    localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF_CYCLES - 1);

    rx_state_t     r_state;
    logic [CW-1:0] r_baud_cnt;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          w_rx_s;
    logic          w_fall;
    logic          w_tick;

`ifdef UART_RX_FRAME_CHK_EN
    logic          r_frame_err;
    assign frame_err = r_frame_err;
`else
    assign frame_err = 1'b0;
`endif

    rx_sync u_rx_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (RX),
        .rx_s (w_rx_s),
        .fall (w_fall)
    );

    assign w_tick = (r_baud_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            rx_data    <= '0;
            rdy        <= 1'b0;
`ifdef UART_RX_FRAME_CHK_EN
            r_frame_err <= 1'b0;
`endif
        end else begin
            if (clr_rdy)
                rdy <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state    <= START;
                        r_baud_cnt <= HALF_LD;
                        r_bit_cnt  <= '0;
                        rdy        <= 1'b0;
                    end
                end

                START: begin
                    if (!w_tick)
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    else if (w_rx_s)
                        r_state <= IDLE;
                    else begin
                        r_state    <= DATA;
                        r_baud_cnt <= BAUD_LD;
                    end
                end

                DATA: begin
                    if (!w_tick)
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    else begin
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        r_baud_cnt <= BAUD_LD;
                        if (r_bit_cnt == 4'd7)
                            r_state <= STOP;
                    end
                end

                STOP: begin
                    if (!w_tick)
                        r_baud_cnt <= r_baud_cnt - 1'b1;
                    else begin
                        // Edge detector stays live here so a back-to-back start is not lost;
                        // the rdy set below is assigned last so it wins over the edge clear.
                        if (w_fall) begin
                            r_state    <= START;
                            r_baud_cnt <= HALF_LD;
                            r_bit_cnt  <= '0;
                            rdy        <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
`ifdef UART_RX_FRAME_CHK_EN
                        if (w_rx_s) begin
                            rx_data     <= r_shift;
                            rdy         <= 1'b1;
                            r_frame_err <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
`else
                        rx_data <= r_shift;
                        rdy     <= 1'b1;
`endif
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

UART receiver that recovers 8N1 command bytes (e.g. 0x47 'G', 0x53 'S') from the BLE module's serial line and presents them to the Segway command/auth logic. It is the receive end of the codebase's `UART_tx`, sitting directly behind the `RX` pin of `Segway`. The block provides:
- metastability hardening of `RX`,
- mid-bit sampling,
- false-start rejection,
- a sticky `rdy`/`clr_rdy` handshake.

## Interface
Parameters:
- BAUD_CYCLES, 2604, clocks per bit (50 MHz / 19200 baud); must be ≥ 16.
- HALF_CYCLES, BAUD_CYCLES/2 (1302), clocks from start-bit detection to the start-bit mid-sample.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- RX  in  1  asynchronous serial input, idle high.
- clr_rdy  in  1  consumer acknowledge; clears `rdy`.
- rx_data  out  8  last received byte, LSB first on the wire.
- rdy  out  1  byte valid, sticky until cleared.
- frame_err  out  1  stop bit sampled low (see Configuration); tied 0 when the feature is compiled out.

## Operation
- **RX synchronizer**
  - Two flops, both reset to 1; `rx_s` is the second flop.
  - A falling edge is detected as `rx_s` low with its previous value high.
- **State machine**
  - IDLE: wait for a falling edge of `rx_s`. On the edge: go to START, load `baud_cnt` with HALF_CYCLES-1, clear `bit_cnt`, clear `rdy`.
  - START: when `baud_cnt` reaches 0, sample `rx_s`.
    - If the sample is high: false start, return to IDLE; `rdy` stays cleared.
    - Otherwise: go to DATA and load BAUD_CYCLES-1.
  - DATA: on each `baud_cnt`==0, shift `rx_s` into the MSB of the 8-bit shift register, increment `bit_cnt`, reload BAUD_CYCLES-1. After the 8th shift, go to STOP.
  - STOP: on `baud_cnt`==0, sample the stop bit. Load `rx_data` from the shift register, set `rdy`, and go to IDLE.
- **Counter widths**: `baud_cnt` is $clog2(BAUD_CYCLES) bits, down-counting; `bit_cnt` is 4 bits.
- **rdy handshake**
  - `rdy` is set in the STOP completion cycle.
  - It is cleared by `clr_rdy`, or by the next start-edge detection.
  - If set and clear occur in the same cycle, set wins.
- `rx_data` holds its value until the next good frame completes. It is never updated mid-frame.
- **Break (RX held low)**
  - A new frame requires a fresh falling edge, so a held-low line cannot retrigger.
  - Without `UART_RX_FRAME_CHK_EN`, a break produces one frame with `rx_data`=0x00 and `rdy`=1.
- **Reset mid-frame**: return to IDLE immediately, with all outputs at their reset values.

## Timing
- Reset values:
  - `rx_data`=0x00, `rdy`=0, `frame_err`=0.
  - State IDLE, counters 0, synchronizer flops at 1.
- Sampling points, measured from the start-edge detection cycle:
  - Start bit at +HALF_CYCLES.
  - Data bit k at +HALF_CYCLES+(k+1)·BAUD_CYCLES.
  - Stop bit at +HALF_CYCLES+9·BAUD_CYCLES.
- Latency: `rdy` rises 2 + HALF_CYCLES + 9·BAUD_CYCLES (+1 registration) clocks after the `RX` pin falls. With defaults this is ≈24,741 clk; the bench tolerance is ±3 clk.
- Back-to-back frames: a start edge arriving in the same cycle as, or any cycle after, STOP completion is accepted. The IDLE edge detector runs in the STOP completion cycle.
- Throughput: one byte per 10·BAUD_CYCLES.

## Configuration
- `UART_RX_FRAME_CHK_EN` defined:
  - A low stop-bit sample sets `frame_err`, leaves `rdy` unchanged and does not update `rx_data`.
  - `frame_err` clears on the next good frame or on `rst`.
- Not defined:
  - The stop bit is ignored.
  - Every completed frame sets `rdy`.
  - `frame_err` is a constant 0.

## Structure
- Package `uart_pkg`:
  - State enum `rx_state_t` {IDLE, START, DATA, STOP}.
  - Constants BAUD_CYCLES_DFLT=2604 and HALF_CYCLES_DFLT=1302, shared with `UART_tx`.
- One sub-module, `rx_sync`: 2-flop synchronizer plus falling-edge detector. Outputs `rx_s` and `fall`, with an async active-high reset that presets to 1.

## Test plan
- **Send 'G'**: drive 0x47 via `UART_tx` → `rdy`=1 at ≈24,741 clk after the start edge, `rx_data`=0x47. Then `clr_rdy` pulse → `rdy`=0 on the next clk.
- **Back-to-back**: send 0x53 then 0xA5 with no idle gap, reading each → `rx_data` matches each in order. The second start edge clears `rdy` if it is still set.
- **False start**: pull `RX` low for 500 clk, then high → no `rdy`, state back to IDLE; a following 0x47 is received correctly.
- **Reset mid-frame**: assert `rst` during data bit 4 of 0xFF → outputs return to reset values immediately; the next full 0x0F frame is received correctly.
- **Set/clear collision**: hold `clr_rdy`=1 through STOP completion of 0x3C → `rdy`=1 in that cycle, then 0 the cycle after.
- **Stop bit forced low**: send 0x55 with the stop bit low.
  - With `UART_RX_FRAME_CHK_EN`: `frame_err`=1, `rdy`=0, `rx_data` unchanged.
  - Without it: `rdy`=1, `rx_data`=0x55.
